// File: rtl/spram_req_ctrl.sv
// Request/response front end for a single-port SRAM with 1-cycle read latency.
// Accepted requests go straight to the SRAM; read data is buffered in a 4-deep FIFO.
module spram_req_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_ceb,
    output logic                  ram_web,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic [BE_WIDTH-1:0]   ram_be,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy
);

    logic [2:0]            count;
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] fifo_mem [4];
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Reserve a FIFO slot for every read in flight so a push can never overflow.
    assign req_ready = ~rst && (({1'b0, count} + {3'b000, in_flight}) < 4'd4);
    assign accept    = req_valid && req_ready;
    assign push      = in_flight;
    assign pop       = (count != 3'd0) && rsp_ready;

    assign rsp_valid = (count != 3'd0);
    assign rsp_rdata = fifo_mem[rd_ptr];
    assign busy      = in_flight || (count != 3'd0);

    always_comb begin
        ram_ceb = 1'b1;
        ram_web = 1'b1;
        ram_a   = '0;
        ram_d   = '0;
        ram_be  = '0;
        if (accept) begin
            ram_ceb = 1'b0;
            ram_web = ~req_we;
            ram_a   = req_addr;
            ram_d   = req_wdata;
            ram_be  = req_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= 1'b0;
            count     <= 3'd0;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
        end else begin
            in_flight <= accept && !req_we;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ram_q;
        end
    end

endmodule

// File: doc/spram_req_ctrl.md
SPRAM_REQ_CTRL -- requirements
Module: spram_req_ctrl

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- ADDR_WIDTH, 9, SRAM word address width.
- DATA_WIDTH, 32, SRAM word width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridable).

REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid&&req_ready.
- req_we  input  1  1=write, 0=read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- req_be  input  BE_WIDTH  byte enables, bit i covers byte i.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  read data consumed when rsp_valid&&rsp_ready.
- rsp_rdata  output  DATA_WIDTH  read data, head of response FIFO.
- ram_ceb  output  1  SRAM chip enable, active-low.
- ram_web  output  1  SRAM write enable, active-low.
- ram_a  output  ADDR_WIDTH  SRAM address.
- ram_d  output  DATA_WIDTH  SRAM write data.
- ram_be  output  BE_WIDTH  SRAM byte enables, active-high.
- ram_q  input  DATA_WIDTH  SRAM read data, valid 1 cycle after a read enable.
- busy  output  1  read in flight or response FIFO non-empty.

Function
REQ-003 On request acceptance the block SHALL issue the access in the same cycle:
- ram_ceb=0, ram_web=~req_we, ram_a=req_addr, ram_d=req_wdata, ram_be=req_be.
REQ-004 In cycles with no accepted request the block SHALL drive:
- ram_ceb=1, ram_web=1, ram_a=0, ram_d=0, ram_be=0.
REQ-005 For reads, ram_be SHALL still equal req_be; the SRAM ignores it.
REQ-006 Writes SHALL produce no response.
REQ-007 A write with req_be=0 SHALL still be issued (ram_ceb=0, ram_web=0) and SHALL leave memory unchanged.
REQ-008 An in-flight flag SHALL be set on the edge ending an accepted read and cleared on the next edge unless another read is accepted.
REQ-009 While the in-flight flag is 1, ram_q SHALL be pushed into the response FIFO at the edge ending that cycle.
REQ-010 Read-accept-to-rsp_valid latency SHALL be exactly 2 clocks when the FIFO is empty.
REQ-011 The response FIFO SHALL be 4 entries deep and strictly FIFO ordered, with a 2-bit wrapping read pointer, a 2-bit wrapping write pointer and a 3-bit count.
REQ-012 FIFO outputs:
- rsp_valid = (count != 0).
- rsp_rdata = entry at the read pointer.
- rsp_rdata holds stable while rsp_valid=1 and rsp_ready=0.
REQ-013 req_ready SHALL be a function of registered state only, with no combinational path from rsp_ready:
- req_ready = ~rst && (count + in_flight) < 4.
- This applies to both reads and writes, so ordering is preserved.
REQ-014 Simultaneous push and pop SHALL leave count unchanged; the pointers SHALL advance independently and wrap from 3 to 0.
REQ-015 A pop with count=0 SHALL have no effect; a push with count=4 SHALL be impossible by construction of REQ-013.
REQ-016 With rsp_ready held at 1, back-to-back reads SHALL sustain one accept per cycle.
REQ-017 busy SHALL equal in_flight || (count != 0).
REQ-018 The SRAM port sequence SHALL follow acceptance order exactly; a read accepted the cycle after a write to the same address returns the new data.

Reset
REQ-019 While rst=1, asynchronously: count=0, both pointers=0, in_flight=0.
REQ-020 While rst=1: rsp_valid=0, busy=0, req_ready=0, ram_ceb=1, ram_web=1, ram_a=0, ram_d=0, ram_be=0.
REQ-021 Reset asserted mid-operation SHALL discard any in-flight read and all buffered responses; no response for those reads SHALL appear after reset release.
REQ-022 FIFO storage contents need not be reset.

Verification
REQ-023 Write then read: write addr 0x005 data 0xDEADBEEF be 0xF, then read 0x005 -> rsp_rdata=0xDEADBEEF exactly 2 clocks after the read accept.
REQ-024 Partial write: write 0x010 = 0x11223344 be 0xF, then 0x010 = 0xAABBCCDD be 0x5, then read 0x010 -> 0x11BB33DD.
REQ-025 Backpressure: rsp_ready=0, 6 consecutive reads (addrs 0..5) -> exactly 4 accepts, then req_ready=0 while count=4. Releasing rsp_ready -> data returned in order 0,1,2,3, then 4,5 accepted and returned.
REQ-026 Throughput: rsp_ready=1, 16 back-to-back reads -> 16 accepts in 16 consecutive cycles, responses in order, rsp_valid continuous from cycle 2.
REQ-027 Reset mid-flight: assert rst the cycle after a read accept -> ram_ceb=1, rsp_valid=0 immediately; after release, no stale response appears and busy=0.
REQ-028 Zero byte-enable: write 0x020 with be 0x0 over a known value 0x12345678 -> subsequent read returns 0x12345678.
